// File: rtl/dht11_controller.sv
// DHT11 read sequencer: issues the host start pulse, walks the sensor's
// response preamble, times the 40 data bits, verifies the checksum and
// enforces the idle interval the sensor needs between reads.
module dht11_controller #(
  parameter int CYCLES_PER_US = 10,
  parameter int START_US      = 18000,
  parameter int RESP_TO_US    = 100,
  parameter int BIT_TO_US     = 100,
  parameter int THRESH_US     = 48,
  parameter int GAP_US        = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic        busy,
  output logic [39:0] data,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_RELEASE   = 4'd2,
    ST_RESP_LOW  = 4'd3,
    ST_RESP_HIGH = 4'd4,
    ST_BIT_LOW   = 4'd5,
    ST_BIT_HIGH  = 4'd6,
    ST_CHECK     = 4'd7,
    ST_GAP       = 4'd8
  } state_t;

  localparam logic [15:0] PRE_LAST   = 16'(CYCLES_PER_US - 1);
  localparam logic [19:0] START_CNT  = 20'(START_US);
  localparam logic [19:0] RESP_CNT   = 20'(RESP_TO_US);
  localparam logic [19:0] BIT_CNT    = 20'(BIT_TO_US);
  localparam logic [19:0] THRESH_CNT = 20'(THRESH_US);
  localparam logic [19:0] GAP_CNT    = 20'(GAP_US);
  localparam logic [19:0] CNT_MAX    = 20'hFFFFF;

  // Modulo-256 sum of the four payload bytes of a frame.
  function automatic logic [7:0] frame_sum(input logic [39:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        r_meta;
  logic        r_sync;
  logic        r_last;
  logic        w_rise;
  logic        w_fall;
  logic [15:0] r_pre;
  logic [19:0] r_us;
  logic [39:0] r_shift;
  logic [5:0]  r_bit_idx;
  logic [39:0] r_data;
  logic        r_valid;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic        r_dht_oe;
  logic        r_busy;
  logic        w_accept;
  logic        w_shift_en;
  logic        w_bit_val;
  logic        w_good;
  logic        w_err_fire;
  logic [1:0]  w_err_val;

  // Two-flop synchronizer for the pad plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_last <= 1'b1;
    end else begin
      r_meta <= dht_in;
      r_sync <= r_meta;
      r_last <= r_sync;
    end
  end

  assign w_rise = r_sync & ~r_last;
  assign w_fall = ~r_sync & r_last;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a line edge always takes priority over a timeout.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_shift_en = 1'b0;
    w_bit_val  = 1'b0;
    w_good     = 1'b0;
    w_err_fire = 1'b0;
    w_err_val  = 2'd0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next   = ST_START_LOW;
          w_accept = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_START_LOW: begin
        if (r_us >= START_CNT) begin
          w_next = ST_RELEASE;
        end else begin
          w_next = ST_START_LOW;
        end
      end
      ST_RELEASE: begin
        if (w_fall) begin
          w_next = ST_RESP_LOW;
        end else if (r_us >= RESP_CNT) begin
          w_next     = ST_GAP;
          w_err_fire = 1'b1;
          w_err_val  = 2'd1;
        end else begin
          w_next = ST_RELEASE;
        end
      end
      ST_RESP_LOW: begin
        if (w_rise) begin
          w_next = ST_RESP_HIGH;
        end else if (r_us >= RESP_CNT) begin
          w_next     = ST_GAP;
          w_err_fire = 1'b1;
          w_err_val  = 2'd1;
        end else begin
          w_next = ST_RESP_LOW;
        end
      end
      ST_RESP_HIGH: begin
        if (w_fall) begin
          w_next = ST_BIT_LOW;
        end else if (r_us >= RESP_CNT) begin
          w_next     = ST_GAP;
          w_err_fire = 1'b1;
          w_err_val  = 2'd1;
        end else begin
          w_next = ST_RESP_HIGH;
        end
      end
      ST_BIT_LOW: begin
        if (w_rise) begin
          w_next = ST_BIT_HIGH;
        end else if (r_us >= BIT_CNT) begin
          w_next     = ST_GAP;
          w_err_fire = 1'b1;
          w_err_val  = 2'd2;
        end else begin
          w_next = ST_BIT_LOW;
        end
      end
      ST_BIT_HIGH: begin
        if (w_fall) begin
          w_shift_en = 1'b1;
          w_bit_val  = (r_us > THRESH_CNT);
          if (r_bit_idx == 6'd39) begin
            w_next = ST_CHECK;
          end else begin
            w_next = ST_BIT_LOW;
          end
        end else if (r_us >= BIT_CNT) begin
          w_next     = ST_GAP;
          w_err_fire = 1'b1;
          w_err_val  = 2'd2;
        end else begin
          w_next = ST_BIT_HIGH;
        end
      end
      ST_CHECK: begin
        w_next = ST_GAP;
        if (frame_sum(r_shift) == r_shift[7:0]) begin
          w_good = 1'b1;
        end else begin
          w_err_fire = 1'b1;
          w_err_val  = 2'd3;
        end
      end
      ST_GAP: begin
        if (r_us >= GAP_CNT) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_GAP;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Timing counters, bit shifter, result registers and registered pad/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre      <= 16'd0;
      r_us       <= 20'd0;
      r_shift    <= 40'd0;
      r_bit_idx  <= 6'd0;
      r_data     <= 40'd0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_dht_oe   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Every state measures its own dwell time from zero.
      if (w_next != r_state) begin
        r_pre <= 16'd0;
        r_us  <= 20'd0;
      end else if (r_pre >= PRE_LAST) begin
        r_pre <= 16'd0;
        if (r_us != CNT_MAX) begin
          r_us <= r_us + 20'd1;
        end
      end else begin
        r_pre <= r_pre + 16'd1;
      end

      if (w_accept) begin
        r_shift   <= 40'd0;
        r_bit_idx <= 6'd0;
      end else if (w_shift_en) begin
        r_shift   <= {r_shift[38:0], w_bit_val};
        r_bit_idx <= r_bit_idx + 6'd1;
      end

      if (w_good) begin
        r_data <= r_shift;
      end

      if (w_accept) begin
        r_err_code <= 2'd0;
      end else if (w_err_fire) begin
        r_err_code <= w_err_val;
      end

      r_valid  <= w_good;
      r_err    <= w_err_fire;
      r_dht_oe <= (w_next == ST_START_LOW);
      r_busy   <= (w_next != ST_IDLE);
    end
  end

  assign dht_oe   = r_dht_oe;
  assign busy     = r_busy;
  assign data     = r_data;
  assign valid    = r_valid;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_dht11_controller.sv
// Bench for dht11_controller: a sensor model drives the open-drain line,
// expected frame outcomes go into a scoreboard queue and a monitor checks
// every valid/err strobe against them.
module tb_dht11_controller;

  localparam int CPU = 10;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_NORESP = 1;
  localparam int MODE_STUCK  = 2;
  localparam int MODE_RESET  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sensor_line = 1'b1;
  logic        dht_in;
  logic        dht_oe;
  logic        busy;
  logic [39:0] data;
  logic        valid;
  logic        err;
  logic [1:0]  err_code;

  // Open-drain pad: host pulls low when enabled, otherwise the sensor (or pull-up) decides.
  assign dht_in = dht_oe ? 1'b0 : sensor_line;

  dht11_controller #(
    .CYCLES_PER_US(10),
    .START_US(20),
    .RESP_TO_US(100),
    .BIT_TO_US(100),
    .THRESH_US(48),
    .GAP_US(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dht_in(dht_in),
    .dht_oe(dht_oe),
    .busy(busy),
    .data(data),
    .valid(valid),
    .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [39:0] data;
    logic [1:0]  code;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [39:0] model_data = 40'd0;
  logic [1:0]  model_code = 2'd0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Checksum rule: payload bytes summed modulo 256 must equal the last byte.
  function automatic bit sum_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic logic [39:0] make_frame(input logic [31:0] payload);
    int s;
    logic [7:0] cs;
    s  = int'(payload[31:24]) + int'(payload[23:16]) + int'(payload[15:8]) + int'(payload[7:0]);
    cs = 8'(s % 256);
    return {payload, cs};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic us(input int u);
    tick(u * CPU);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick(1);
      n++;
    end
    if (busy !== 1'b0) begin
      chk("busy_fall_timeout", 40'(busy), 40'd0);
    end
  endtask

  // One host read with the sensor model answering according to mode.
  task automatic do_read(input logic [39:0] f, input int mode, input bit poke);
    int n;
    int h;
    if (mode == MODE_NORESP) begin
      sb_q.push_back('{1'b1, model_data, 2'd1});
      model_code = 2'd1;
    end else if (mode == MODE_STUCK) begin
      sb_q.push_back('{1'b1, model_data, 2'd2});
      model_code = 2'd2;
    end else if (mode == MODE_RESET) begin
      model_code = 2'd0;
    end else if (sum_ok(f)) begin
      model_data = f;
      model_code = 2'd0;
      sb_q.push_back('{1'b0, f, 2'd0});
    end else begin
      sb_q.push_back('{1'b1, model_data, 2'd3});
      model_code = 2'd3;
    end

    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("oe_rise_after_start", 40'(dht_oe), 40'd1);
    chk("busy_rise_after_start", 40'(busy), 40'd1);

    n = 0;
    while (dht_oe === 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    chk_range("start_low_cycles", n, 190, 210);

    if (mode == MODE_NORESP) begin
      n = 0;
      while (err !== 1'b1 && n < 1500) begin
        tick(1);
        n++;
      end
      chk_range("noresp_err_delay", n, 990, 1010);
      return;
    end

    us(20);
    sensor_line = 1'b0;
    us(80);
    sensor_line = 1'b1;
    us(80);

    for (int i = 0; i < 40; i++) begin
      sensor_line = 1'b0;
      us(int'($urandom_range(4, 8)));
      sensor_line = 1'b1;
      if (mode == MODE_STUCK && i == 17) begin
        n = 0;
        while (err !== 1'b1 && n < 1500) begin
          tick(1);
          n++;
        end
        chk_range("stuck_err_delay", n, 995, 1015);
        return;
      end
      if (mode == MODE_RESET && i == 20) begin
        us(5);
        rst = 1'b1;
        tick(1);
        chk("rst_dht_oe", 40'(dht_oe), 40'd0);
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_data", data, 40'd0);
        chk("rst_valid", 40'(valid), 40'd0);
        chk("rst_err", 40'(err), 40'd0);
        chk("rst_err_code", 40'(err_code), 40'd0);
        rst = 1'b0;
        model_data = 40'd0;
        tick(2);
        return;
      end
      if (f[39 - i]) begin
        h = int'($urandom_range(56, 62));
      end else begin
        h = int'($urandom_range(12, 24));
      end
      if (poke && i == 10) begin
        tick(20);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_in_bit_high_oe", 40'(dht_oe), 40'd0);
        tick(h * CPU - 21);
      end else begin
        us(h);
      end
    end
    sensor_line = 1'b0;
    us(5);
    sensor_line = 1'b1;
  endtask

  // Monitor: every valid/err strobe consumes one expected outcome.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && (valid === 1'b1 || err === 1'b1)) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b data=0x%0h code=%0d", valid, err, data, err_code);
      end else begin
        e = sb_q.pop_front();
        if (valid !== !e.is_err || err !== e.is_err || data !== e.data || err_code !== e.code) begin
          n_bad++;
          $display("FAIL strobe: got valid=%0b err=%0b data=0x%0h code=%0d expected valid=%0b err=%0b data=0x%0h code=%0d",
                   valid, err, data, err_code, !e.is_err, e.is_err, e.data, e.code);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic [39:0] f;
    rst = 1'b1;
    tick(3);
    chk("reset_dht_oe", 40'(dht_oe), 40'd0);
    chk("reset_busy", 40'(busy), 40'd0);
    chk("reset_data", data, 40'd0);
    chk("reset_valid", 40'(valid), 40'd0);
    chk("reset_err", 40'(err), 40'd0);
    chk("reset_err_code", 40'(err_code), 40'd0);
    rst = 1'b0;
    tick(2);

    // Clean read, with start poked during a bit high phase and during GAP.
    do_read(40'h3700190050, MODE_NORMAL, 1'b1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_in_gap_oe", 40'(dht_oe), 40'd0);
    chk("start_in_gap_busy", 40'(busy), 40'd1);
    wait_idle(n);
    tick(20);
    chk("start_not_queued", 40'(busy), 40'd0);
    chk("read1_data", data, model_data);
    chk("read1_err_code", 40'(err_code), 40'(model_code));

    // Bad checksum keeps the previous frame.
    do_read(40'h3700190051, MODE_NORMAL, 1'b0);
    wait_idle(n);
    chk("badsum_data_held", data, model_data);
    chk("badsum_err_code", 40'(err_code), 40'(model_code));

    // No response from the sensor.
    do_read(40'h3700190050, MODE_NORESP, 1'b0);
    wait_idle(n);
    chk("noresp_err_code", 40'(err_code), 40'(model_code));

    // Line stuck high during bit 17.
    do_read(40'h3700190050, MODE_STUCK, 1'b0);
    wait_idle(n);
    chk_range("gap_after_err_cycles", n, 490, 512);
    chk("stuck_err_code", 40'(err_code), 40'(model_code));

    // Reset in the middle of bit 20.
    do_read(40'h3700190050, MODE_RESET, 1'b0);

    // Clean random read after reset.
    f = make_frame($urandom);
    do_read(f, MODE_NORMAL, 1'b0);
    wait_idle(n);
    chk("post_reset_data", data, f);
    chk("post_reset_err_code", 40'(err_code), 40'(model_code));

    tick(5);
    chk("scoreboard_drained", 40'(sb_q.size()), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
